// File: rtl/seq_detector_pkg.sv
// Shared constants and helpers for the programmable sequence detector.
// Build with SEQDET_MATCH_CNT_EN defined to enable the saturating match counter.
package seq_detector_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;

  // Widest pattern the mask helper supports.
  localparam int MASK_W = 64;

  // A requested length longer than the hardware supports uses the full width.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

  // Ones in the low `len` bits. Used to ignore pattern and history bits above the active length.
  function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
    logic [MASK_W-1:0] m;
    if (len >= MASK_W) m = '1;
    else               m = (MASK_W'(1) << len) - MASK_W'(1);
    return m;
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Holds the history shift register and the fill counter.
// Compares the last len-1 bits plus the current bit against the pattern, giving the Mealy output y.
module seq_match_core
  import seq_detector_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  input  logic               in_valid,
  input  logic               x,
  output logic               y
);

  localparam int FILL_W = LEN_W + 1;

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MASK_W-1:0]  mask_full;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] window;
  logic               fill_ok;
  logic               match;

  always_comb begin
    mask_full = len_mask(32'(len));
    mask      = mask_full[MAX_LEN-1:0];
    window    = {hist_q[MAX_LEN-2:0], x};
    // fill >= len-1, written as fill+1 >= len so len = 0 cannot underflow.
    fill_ok   = (FILL_W'(fill_q) + FILL_W'(1)) >= FILL_W'(len);
    match     = in_valid && !clear && (len != '0) && fill_ok &&
                ((window & mask) == (pattern & mask));
  end

  assign y = match;

  // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = {hist_q[MAX_LEN-2:0], x};
      if (match && !overlap)
        fill_d = '0;
      else if (fill_q != LEN_W'(MAX_LEN))
        fill_d = fill_q + LEN_W'(1);
    end
  end

  // NOTE: flops use non-blocking assignment, so every register samples the values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable Mealy serial sequence detector with config registers, registered y_q and an optional counter.
// Defining SEQDET_MATCH_CNT_EN adds the saturating match counter; otherwise match_cnt and cnt_sat read as 0.
module seq_detector_prog
  import seq_detector_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               x,
  output logic               y,
  output logic               y_q,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic               y_q_d;

  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
      overlap_d = cfg_overlap;
    end
  end

  // The core suppresses y during cfg_load, so this also clears y_q on a load.
  assign y_q_d = y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      y_q       <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      y_q       <= y_q_d;
    end
  end

  seq_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .clear    (cfg_load),
    .pattern  (pattern_q),
    .len      (len_q),
    .overlap  (overlap_q),
    .in_valid (in_valid),
    .x        (x),
    .y        (y)
  );

`ifdef SEQDET_MATCH_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (cfg_load) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (y && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
      sat_d = (cnt_d == CNT_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;
`else
  assign match_cnt = '0;
  assign cnt_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// Randomised scoreboard bench for seq_detector_prog.
// A bit-list reference model pushes expectations, and a negedge monitor compares them with the DUT.
module tb_seq_detector_prog;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               in_valid;
  logic               x;
  logic               y;
  logic               y_q;
  logic [CNT_W-1:0]   match_cnt;
  logic               cnt_sat;

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .in_valid    (in_valid),
    .x           (x),
    .y           (y),
    .y_q         (y_q),
    .match_cnt   (match_cnt),
    .cnt_sat     (cnt_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit y;
    bit y_q;
    int cnt;
    bit sat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the bits seen since the last flush, kept as a plain list.
  bit [MAX_LEN-1:0] m_pattern;
  int               m_len;
  bit               m_ovl;
  bit               fresh[$];
  bit               m_prev_y;
  int               m_cnt;
  bit               m_sat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pattern = '0;
    m_len     = 0;
    m_ovl     = 1'b0;
    fresh.delete();
    m_prev_y  = 1'b0;
    m_cnt     = 0;
    m_sat     = 1'b0;
  endtask

  function automatic bit model_match(input bit valid, input bit xin);
    int n;
    bit b;
    if (!valid || m_len == 0 || fresh.size() < m_len - 1) return 1'b0;
    n = fresh.size();
    for (int i = 0; i < m_len; i++) begin
      b = (i == m_len - 1) ? xin : fresh[n - (m_len - 1) + i];
      if (b != m_pattern[m_len - 1 - i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drive(input bit load, input bit [MAX_LEN-1:0] pat, input int len,
                       input bit ovl, input bit valid, input bit xin);
    exp_t e;
    bit   ey;
    @(posedge clk);
    #1;
    cfg_load    = load;
    cfg_pattern = pat;
    cfg_len     = LEN_W'(len);
    cfg_overlap = ovl;
    in_valid    = valid;
    x           = xin;
    ey    = !load && model_match(valid, xin);
    e.y   = ey;
    e.y_q = m_prev_y;
    e.cnt = m_cnt;
    e.sat = m_sat;
    sb.push_back(e);
    if (load) begin
      m_pattern = pat;
      m_len     = (len > MAX_LEN) ? MAX_LEN : len;
      m_ovl     = ovl;
      fresh.delete();
      m_cnt     = 0;
      m_sat     = 1'b0;
    end else if (valid) begin
      if (ey && !m_ovl) begin
        fresh.delete();
      end else begin
        fresh.push_back(xin);
        if (fresh.size() > MAX_LEN) void'(fresh.pop_front());
      end
`ifdef SEQDET_MATCH_CNT_EN
      if (ey && m_cnt < CNT_MAX) m_cnt++;
      m_sat = (m_cnt == CNT_MAX);
`endif
    end
    m_prev_y = ey;
  endtask

  task automatic load_cfg(input bit [MAX_LEN-1:0] pat, input int len, input bit ovl);
    drive(1'b1, pat, len, ovl, 1'b0, 1'b0);
  endtask

  task automatic bit_in(input bit b);
    drive(1'b0, '0, 0, 1'b0, 1'b1, b);
  endtask

  task automatic idle();
    drive(1'b0, '0, 0, 1'b0, 1'b0, $urandom_range(0, 1) == 1);
  endtask

  // Monitor: y is visible every cycle, so one expectation is consumed per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("y",         32'(y),         32'(e.y));
        check("y_q",       32'(y_q),       32'(e.y_q));
        check("match_cnt", 32'(match_cnt), 32'(e.cnt));
        check("cnt_sat",   32'(cnt_sat),   32'(e.sat));
      end
    end
  end

  bit s000111[14] = '{0,1,0,0,0,1,1,1,0,0,0,1,1,1};
  bit s10101[5]   = '{1,0,1,0,1};
  int exp_cnt2;
  int exp_cnt_sat;
  bit exp_sat;

  initial begin
    rst = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; in_valid = 1'b0; x = 1'b0;
    model_reset();
`ifdef SEQDET_MATCH_CNT_EN
    exp_cnt2 = 2; exp_cnt_sat = CNT_MAX; exp_sat = 1'b1;
`else
    exp_cnt2 = 0; exp_cnt_sat = 0; exp_sat = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_y_q", 32'(y_q), 32'(m_prev_y));
    check("rst_cnt", 32'(match_cnt), 32'(m_cnt));
    rst = 1'b0;

    // After reset the detector is disabled (len = 0).
    repeat (4) bit_in(1'b1);
    repeat (4) bit_in(1'b0);

    // Pattern 000111, non-overlapping.
    load_cfg(8'b0000_0111, 6, 1'b0);
    foreach (s000111[i]) bit_in(s000111[i]);
    idle();
    check("cnt_000111", 32'(match_cnt), 32'(exp_cnt2));

    // The same stream with gap cycles between bits.
    load_cfg(8'b0000_0111, 6, 1'b0);
    foreach (s000111[i]) begin
      bit_in(s000111[i]);
      repeat ($urandom_range(0, 2)) idle();
    end

    // Pattern 101, overlapping and then non-overlapping.
    load_cfg(8'b0000_0101, 3, 1'b1);
    foreach (s10101[i]) bit_in(s10101[i]);
    load_cfg(8'b0000_0101, 3, 1'b0);
    foreach (s10101[i]) bit_in(s10101[i]);

    // Reload in mid-stream, followed by a load in the same cycle as a valid bit.
    load_cfg(8'b0000_0111, 6, 1'b0);
    for (int i = 0; i < 5; i++) bit_in(s000111[i]);
    load_cfg(8'b0000_0011, 2, 1'b1);
    repeat (3) bit_in(1'b1);
    drive(1'b1, 8'b0000_0011, 2, 1'b1, 1'b1, 1'b1);
    repeat (3) bit_in(1'b1);

    // Lengths above MAX_LEN clamp to MAX_LEN, and len = 1 compares a single bit.
    load_cfg(8'b1010_1010, 15, 1'b1);
    repeat (3) begin
      bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b0);
    end
    load_cfg(8'b0000_0000, 1, 1'b0);
    repeat (4) bit_in(1'b0);

    // Saturation: pattern 1, len 1, five ones.
    load_cfg(8'b0000_0001, 1, 1'b0);
    repeat (5) bit_in(1'b1);
    idle();
    check("sat_cnt", 32'(match_cnt), 32'(exp_cnt_sat));
    check("sat_flag", 32'(cnt_sat), 32'(exp_sat));

    // Async reset between clock edges while y_q is high.
    load_cfg(8'b0000_0011, 2, 1'b1);
    bit_in(1'b1);
    bit_in(1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_load = 1'b0;
    check("pre_rst_y_q", 32'(y_q), 32'(m_prev_y));
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_y_q", 32'(y_q), 32'(m_prev_y));
    check("async_rst_cnt", 32'(match_cnt), 32'(m_cnt));
    check("async_rst_sat", 32'(cnt_sat), 32'(m_sat));
    rst = 1'b0;
    repeat (6) bit_in(1'b1);

    // Random traffic with occasional reconfiguration.
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 49) == 0)
        drive(1'b1, MAX_LEN'($urandom),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4),
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      else
        drive(1'b0, '0, 0, 1'b0, $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1);
    end

    repeat (3) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cfg_load = 1'b0;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
